tt_um_alu_regfile_seg: RTL and testbench
========================================

// Module: tt_um_alu_regfile_seg
// PURPOSE
//  Parametrised accumulator + register-file engine driven from TinyTapeout pins.
//  A write-enable strobe launches one command (opcode/addr/data); a multi-cycle FSM executes it.
//  The accumulator low nibble is shown as a hex digit on the seven-segment outputs.
//  Flags are driven on uio. Generalises the fixed 4-bit store/display block: width, depth, ALU ops, bulk clear.
// PARAMETERS
//  DATA_W  4  accumulator/register width (>=4); arithmetic modulo 2^DATA_W
//  ADDR_W  4  register-file address width; depth = 2^ADDR_W
//  SYNC_N  2  synchroniser stages on in_write_enable (>=2)
// PORTS
//  clk              in   1       system clock
//  rst_n            in   1       async active-low reset
//  ena              in   1       design selected; 0 = ignore new commands
//  in_data          in   DATA_W  immediate operand
//  in_addr          in   ADDR_W  register index
//  in_opcode        in   4       operation code
//  in_write_enable  in   1       command strobe (async pin, rising edge launches)
//  uo_out           out  8       {busy, seg[6:0]} seg = gfedcba, active high
//  uio_out          out  8       {4'b0, err, carry, zero, 1'b0}
//  uio_oe           out  8       constant 8'b0000_1110
//  result_out       out  DATA_W  accumulator value
// BEHAVIOUR
//  Reset: acc=0, flags=0, regfile=0, FSM=IDLE. uo_out=8'h3F ('0'). uio_out=0. result_out=0.
//  Strobe: SYNC_N-flop sync, then edge register; 1-cycle pulse 'go' on a synced 0->1.
//  Accept: go & ena & IDLE latches opcode/addr/data. go while busy/ena=0 dropped; sets err (sticky).
//  err clears on next accepted command unless that opcode is reserved.
//  FSM: IDLE -> FETCH (registered read regfile[addr]) -> EXEC (ALU, acc/flag update) -> WB -> IDLE.
//  CLR: IDLE -> CLEAR (one reg per cycle, idx 0..2^ADDR_W-1) -> IDLE.
//  busy=1 in every state != IDLE. Normal command: busy 3 cycles. CLR: 2^ADDR_W cycles.
//  Opcodes (R = regfile[addr]):
//   0 NOP
//   1 LDI  acc=data
//   2 LD   acc=R
//   3 ST   R=acc (written in WB)
//   4 ADD  {c,acc}=acc+R
//   5 SUB  acc=acc-R, c=borrow
//   6 AND, 7 OR, 8 XOR  acc=acc op R
//   9 SHL  c=acc[MSB], acc<<1
//   A SHR  c=acc[0], acc>>1
//   B INC  R=R+1 (acc unchanged)
//   C CLR  all R=0
//   D..F   reserved: NOP, set err
//  zero updated on every acc-writing op (acc==0 after). carry updated only by 4,5,9,A; else held.
//  Display: seg decoded from acc[3:0] and registered, valid the cycle after acc changes.
//  Hex map: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
//  ST then LD to the same addr back-to-back: LD sees the new value (WB completes before next FETCH).
//  rst_n low mid-operation (incl. CLEAR): immediate return to reset state; partial CLEAR is discarded.
//  ena low mid-operation: the current command completes; the display holds its last value.
// STRUCTURE
//  Package alu_regfile_pkg: opcode localparams, FSM state encoding, seg7 hex table constants.
//  Sub-module seg7_hex_decoder (4-bit in, 7-bit out, combinational), registered in parent.
//  Regfile is a flop array (no SRAM macro); ALU is inline in EXEC.
// TESTING
//  1 Release reset, idle 5 cycles -> uo_out=8'h3F, uio_out=0, uio_oe=8'h0E.
//  2 LDI 5; ST r3; LDI C; ADD r3 -> acc=1, carry=1, zero=0, uo_out[6:0]=06.
//  3 LDI 3; ST r0; LDI 2; SUB r0 -> acc=F, carry=1, uo_out[6:0]=71.
//    Follow with XOR r0 -> acc=C, seg=39.
//  4 ST r7 (acc=C); CLR -> busy high 16 cycles (ADDR_W=4); then LD r7 -> acc=0, zero=1.
//  5 Strobe during ADD busy -> ADD completes, second command dropped, err=1.
//    Next accepted LDI 6 -> err=0, seg=7D.
//  6 Assert rst_n low at CLEAR idx 5 -> busy=0, acc=0 asynchronously. Then LD r15 -> 0.

Source files
------------

// File: rtl/alu_regfile_pkg.sv
// Shared constants for the accumulator/register-file engine: opcodes, FSM
// state encoding and the seven-segment hex table.
package alu_regfile_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDI = 4'h1;
  localparam logic [3:0] OP_LD  = 4'h2;
  localparam logic [3:0] OP_ST  = 4'h3;
  localparam logic [3:0] OP_ADD = 4'h4;
  localparam logic [3:0] OP_SUB = 4'h5;
  localparam logic [3:0] OP_AND = 4'h6;
  localparam logic [3:0] OP_OR  = 4'h7;
  localparam logic [3:0] OP_XOR = 4'h8;
  localparam logic [3:0] OP_SHL = 4'h9;
  localparam logic [3:0] OP_SHR = 4'hA;
  localparam logic [3:0] OP_INC = 4'hB;
  localparam logic [3:0] OP_CLR = 4'hC;
  localparam logic [3:0] OP_RSV = 4'hD;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_WB    = 3'd3,
    ST_CLEAR = 3'd4
  } state_e;

  // Digit d occupies bits [7*d +: 7]; segments are gfedcba, active high.
  localparam logic [111:0] SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/seg7_hex_decoder.sv
// Combinational hex digit to seven-segment (gfedcba, active high) decoder.
module seg7_hex_decoder
  import alu_regfile_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [6:0] seg_o
);

  assign seg_o = SEG_TABLE[7*digit_i +: 7];

endmodule

// File: rtl/tt_um_alu_regfile_seg.sv
// Accumulator + register-file engine: a synchronised strobe launches one
// command, a multi-cycle FSM executes it, acc[3:0] drives the display.
module tt_um_alu_regfile_seg
  import alu_regfile_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 4,
  parameter int SYNC_N = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic [DATA_W-1:0] in_data,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [3:0]        in_opcode,
  input  logic              in_write_enable,
  output logic [7:0]        uo_out,
  output logic [7:0]        uio_out,
  output logic [7:0]        uio_oe,
  output logic [DATA_W-1:0] result_out
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [SYNC_N-1:0] sync_q, sync_d;
  logic              edge_q, edge_d;
  state_e            state_q, state_d;
  logic [3:0]        op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d, clr_idx_q, clr_idx_d;
  logic [DATA_W-1:0] data_q, data_d, acc_q, acc_d, rd_q, rd_d;
  logic              carry_q, carry_d, zero_q, zero_d, err_q, err_d;
  logic [6:0]        seg_q, seg_d, seg_dec;
  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [DATA_W:0]   sum, diff;
  logic              go, accept, acc_wr;

  seg7_hex_decoder u_dec (
    .digit_i (acc_q[3:0]),
    .seg_o   (seg_dec)
  );

  // go is a single-cycle pulse on a synchronised low-to-high strobe transition.
  assign go     = sync_q[SYNC_N-1] & ~edge_q;
  assign accept = go & ena & (state_q == ST_IDLE);
  assign sum    = {1'b0, acc_q} + {1'b0, rd_q};
  assign diff   = {1'b0, acc_q} - {1'b0, rd_q};

  always_comb begin
    sync_d    = {sync_q[SYNC_N-2:0], in_write_enable};
    edge_d    = sync_q[SYNC_N-1];
    state_d   = state_q;
    op_d      = op_q;
    addr_d    = addr_q;
    data_d    = data_q;
    clr_idx_d = clr_idx_q;
    acc_d     = acc_q;
    rd_d      = rd_q;
    carry_d   = carry_q;
    zero_d    = zero_q;
    err_d     = err_q;
    regs_d    = regs_q;
    acc_wr    = 1'b0;
    seg_d     = ena ? seg_dec : seg_q;

    if (accept) begin
      op_d      = in_opcode;
      addr_d    = in_addr;
      data_d    = in_data;
      clr_idx_d = '0;
      err_d     = (in_opcode >= OP_RSV);
      state_d   = (in_opcode == OP_CLR) ? ST_CLEAR : ST_FETCH;
    end else if (go) begin
      err_d = 1'b1;
    end

    case (state_q)
      ST_FETCH: begin
        rd_d    = regs_q[addr_q];
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        acc_wr = 1'b1;
        case (op_q)
          OP_LDI: acc_d = data_q;
          OP_LD:  acc_d = rd_q;
          OP_ADD: {carry_d, acc_d} = sum;
          OP_SUB: {carry_d, acc_d} = diff;
          OP_AND: acc_d = acc_q & rd_q;
          OP_OR:  acc_d = acc_q | rd_q;
          OP_XOR: acc_d = acc_q ^ rd_q;
          OP_SHL: {carry_d, acc_d} = {acc_q, 1'b0};
          OP_SHR: {acc_d, carry_d} = {1'b0, acc_q};
          default: acc_wr = 1'b0;
        endcase
        if (acc_wr) zero_d = (acc_d == '0);
        state_d = ST_WB;
      end
      ST_WB: begin
        if (op_q == OP_ST)  regs_d[addr_q] = acc_q;
        if (op_q == OP_INC) regs_d[addr_q] = rd_q + 1'b1;
        state_d = ST_IDLE;
      end
      ST_CLEAR: begin
        regs_d[clr_idx_q] = '0;
        clr_idx_d         = clr_idx_q + 1'b1;
        if (clr_idx_q == ADDR_W'(DEPTH - 1)) state_d = ST_IDLE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= '0;
      edge_q    <= 1'b0;
      state_q   <= ST_IDLE;
      op_q      <= OP_NOP;
      addr_q    <= '0;
      data_q    <= '0;
      clr_idx_q <= '0;
      acc_q     <= '0;
      rd_q      <= '0;
      carry_q   <= 1'b0;
      zero_q    <= 1'b0;
      err_q     <= 1'b0;
      seg_q     <= SEG_TABLE[6:0];
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
    end else begin
      sync_q    <= sync_d;
      edge_q    <= edge_d;
      state_q   <= state_d;
      op_q      <= op_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      clr_idx_q <= clr_idx_d;
      acc_q     <= acc_d;
      rd_q      <= rd_d;
      carry_q   <= carry_d;
      zero_q    <= zero_d;
      err_q     <= err_d;
      seg_q     <= seg_d;
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= regs_d[i];
    end
  end

  assign uo_out     = {(state_q != ST_IDLE), seg_q};
  assign uio_out    = {4'b0000, err_q, carry_q, zero_q, 1'b0};
  assign uio_oe     = 8'b0000_1110;
  assign result_out = acc_q;

endmodule

// File: tb/tb_tt_um_alu_regfile_seg.sv
// Bench for tt_um_alu_regfile_seg: directed scenarios plus random commands
// checked against an arithmetic model of the accumulator and register file.
module tb_tt_um_alu_regfile_seg;

  localparam int DW  = 4;
  localparam int AW  = 4;
  localparam int MOD = 1 << DW;
  localparam int DEP = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ena = 1'b1;
  logic [DW-1:0] in_data = '0;
  logic [AW-1:0] in_addr = '0;
  logic [3:0]    in_opcode = '0;
  logic          in_write_enable = 1'b0;
  logic [7:0]    uo_out, uio_out, uio_oe;
  logic [DW-1:0] result_out;

  int n_checks = 0;
  int n_pass = 0;

  // reference model state
  int m_regs [DEP];
  int m_acc, m_carry, m_zero, m_err;
  logic [DW-1:0] exp_q [$];
  logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  tt_um_alu_regfile_seg #(.DATA_W(DW), .ADDR_W(AW), .SYNC_N(2)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .ena             (ena),
    .in_data         (in_data),
    .in_addr         (in_addr),
    .in_opcode       (in_opcode),
    .in_write_enable (in_write_enable),
    .uo_out          (uo_out),
    .uio_out         (uio_out),
    .uio_oe          (uio_oe),
    .result_out      (result_out)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < DEP; i++) m_regs[i] = 0;
    m_acc = 0; m_carry = 0; m_zero = 0; m_err = 0;
    exp_q.delete();
  endtask

  task automatic model_cmd(input int op, input int addr, input int data);
    int r;
    r = m_regs[addr];
    m_err = (op >= 13) ? 1 : 0;
    case (op)
      1:  m_acc = data;
      2:  m_acc = r;
      3:  m_regs[addr] = m_acc;
      4:  begin m_carry = (m_acc + r >= MOD) ? 1 : 0; m_acc = (m_acc + r) % MOD; end
      5:  begin m_carry = (m_acc < r) ? 1 : 0; m_acc = (m_acc - r + MOD) % MOD; end
      6:  m_acc = m_acc & r;
      7:  m_acc = m_acc | r;
      8:  m_acc = m_acc ^ r;
      9:  begin m_carry = (m_acc >= MOD / 2) ? 1 : 0; m_acc = (m_acc * 2) % MOD; end
      10: begin m_carry = m_acc % 2; m_acc = m_acc / 2; end
      11: m_regs[addr] = (r + 1) % MOD;
      12: for (int i = 0; i < DEP; i++) m_regs[i] = 0;
      default: ;
    endcase
    if (op == 1 || op == 2 || (op >= 4 && op <= 10)) m_zero = (m_acc == 0) ? 1 : 0;
    exp_q.push_back(DW'(m_acc));
  endtask

  // driver: one strobe, then count busy cycles until idle (-1 on timeout)
  task automatic drive_cmd(input int op, input int addr, input int data, output int busy_cnt);
    bit seen, done;
    @(negedge clk);
    in_opcode = 4'(op); in_addr = AW'(addr); in_data = DW'(data);
    in_write_enable = 1'b1;
    busy_cnt = 0; seen = 0; done = 0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if (i == 2) in_write_enable = 1'b0;
      if (uo_out[7]) begin busy_cnt++; seen = 1; end
      else if (seen) done = 1;
    end
    in_write_enable = 1'b0;
    if (!done) busy_cnt = -1;
    repeat (2) @(negedge clk);
  endtask

  task automatic cmd(input int op, input int addr, input int data);
    int bc;
    drive_cmd(op, addr, data, bc);
    model_cmd(op, addr, data);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    repeat (5) @(negedge clk);
    n_checks++; if (uo_out !== 8'h3F) $display("FAIL reset_uo got %h want 3f", uo_out); else n_pass++;
    n_checks++; if (uio_out !== 8'h00) $display("FAIL reset_uio got %h want 00", uio_out); else n_pass++;
    n_checks++; if (uio_oe !== 8'h0E) $display("FAIL reset_oe got %h want 0e", uio_oe); else n_pass++;
    n_checks++; if (result_out !== 4'h0) $display("FAIL reset_acc got %h want 0", result_out); else n_pass++;
  endtask

  task automatic test_add();
    int bc;
    cmd(1, 0, 5); cmd(3, 3, 0); cmd(1, 0, 12);
    drive_cmd(4, 3, 0, bc); model_cmd(4, 3, 0);
    n_checks++; if (bc !== 3) $display("FAIL add_busy got %0d want 3", bc); else n_pass++;
    n_checks++; if (result_out !== 4'h1) $display("FAIL add_acc got %h want 1", result_out); else n_pass++;
    n_checks++; if (uio_out[3:1] !== 3'b010) $display("FAIL add_flags got %b want 010", uio_out[3:1]); else n_pass++;
    n_checks++; if (uo_out[6:0] !== 7'h06) $display("FAIL add_seg got %h want 06", uo_out[6:0]); else n_pass++;
  endtask

  task automatic test_sub_xor();
    cmd(1, 0, 3); cmd(3, 0, 0); cmd(1, 0, 2); cmd(5, 0, 0);
    n_checks++; if (result_out !== 4'hF) $display("FAIL sub_acc got %h want f", result_out); else n_pass++;
    n_checks++; if (uio_out[2] !== 1'b1) $display("FAIL sub_borrow got %b want 1", uio_out[2]); else n_pass++;
    n_checks++; if (uo_out[6:0] !== 7'h71) $display("FAIL sub_seg got %h want 71", uo_out[6:0]); else n_pass++;
    cmd(8, 0, 0);
    n_checks++; if (result_out !== 4'hC) $display("FAIL xor_acc got %h want c", result_out); else n_pass++;
    n_checks++; if (uo_out[6:0] !== 7'h39) $display("FAIL xor_seg got %h want 39", uo_out[6:0]); else n_pass++;
  endtask

  task automatic test_clear();
    int bc;
    cmd(3, 7, 0);
    drive_cmd(12, 0, 0, bc); model_cmd(12, 0, 0);
    n_checks++; if (bc !== DEP) $display("FAIL clr_busy got %0d want %0d", bc, DEP); else n_pass++;
    cmd(2, 7, 0);
    n_checks++; if (result_out !== 4'h0) $display("FAIL clr_ld_acc got %h want 0", result_out); else n_pass++;
    n_checks++; if (uio_out[1] !== 1'b1) $display("FAIL clr_ld_zero got %b want 1", uio_out[1]); else n_pass++;
  endtask

  task automatic test_busy_drop();
    int bc;
    bit seen, done;
    cmd(1, 0, 7); cmd(3, 3, 0); cmd(1, 0, 4);
    model_cmd(4, 3, 0);
    m_err = 1;
    @(negedge clk); in_opcode = 4'h4; in_addr = 4'h3; in_write_enable = 1'b1;
    @(negedge clk); in_write_enable = 1'b0;
    @(negedge clk); in_write_enable = 1'b1;
    bc = 0; seen = 0; done = 0;
    for (int i = 0; i < 30 && !done; i++) begin
      @(negedge clk);
      if (uo_out[7]) begin bc++; seen = 1; end
      else if (seen) done = 1;
    end
    in_write_enable = 1'b0;
    repeat (4) @(negedge clk);
    n_checks++; if (bc !== 3) $display("FAIL drop_busy got %0d want 3", bc); else n_pass++;
    n_checks++; if (result_out !== 4'hB) $display("FAIL drop_acc got %h want b", result_out); else n_pass++;
    n_checks++; if (uio_out[3] !== 1'b1) $display("FAIL drop_err got %b want 1", uio_out[3]); else n_pass++;
    cmd(1, 0, 6);
    n_checks++; if (uio_out[3] !== 1'b0) $display("FAIL err_clear got %b want 0", uio_out[3]); else n_pass++;
    n_checks++; if (uo_out[6:0] !== 7'h7D) $display("FAIL ldi6_seg got %h want 7d", uo_out[6:0]); else n_pass++;
  endtask

  task automatic test_ena_and_reserved();
    int bc;
    bit any_busy;
    ena = 1'b0; any_busy = 0;
    @(negedge clk); in_opcode = 4'h1; in_data = 4'h9; in_write_enable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 2) in_write_enable = 1'b0;
      if (uo_out[7]) any_busy = 1;
    end
    ena = 1'b1; m_err = 1;
    n_checks++; if (any_busy !== 1'b0) $display("FAIL ena_busy got %b want 0", any_busy); else n_pass++;
    n_checks++; if (result_out !== DW'(m_acc)) $display("FAIL ena_acc got %h want %h", result_out, m_acc); else n_pass++;
    n_checks++; if (uio_out[3] !== 1'b1) $display("FAIL ena_err got %b want 1", uio_out[3]); else n_pass++;
    cmd(1, 0, 2);
    drive_cmd(14, 0, 0, bc); model_cmd(14, 0, 0);
    n_checks++; if (uio_out[3] !== 1'b1) $display("FAIL rsv_err got %b want 1", uio_out[3]); else n_pass++;
    n_checks++; if (result_out !== 4'h2) $display("FAIL rsv_acc got %h want 2", result_out); else n_pass++;
  endtask

  task automatic test_back_to_back();
    cmd(1, 0, 10); cmd(3, 4, 0); cmd(1, 0, 0); cmd(2, 4, 0);
    n_checks++; if (result_out !== 4'hA) $display("FAIL st_ld_acc got %h want a", result_out); else n_pass++;
    cmd(11, 4, 0); cmd(11, 4, 0); cmd(2, 4, 0);
    n_checks++; if (result_out !== 4'hC) $display("FAIL inc_acc got %h want c", result_out); else n_pass++;
  endtask

  task automatic test_reset_mid_clear();
    int bc;
    cmd(1, 0, 9); cmd(3, 15, 0);
    @(negedge clk); in_opcode = 4'hC; in_write_enable = 1'b1;
    bc = 0;
    for (int i = 0; i < 30 && bc < 6; i++) begin
      @(negedge clk);
      if (uo_out[7]) bc++;
    end
    n_checks++; if (bc !== 6) $display("FAIL midclr_reach got %0d want 6", bc); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++; if (uo_out !== 8'h3F) $display("FAIL midclr_uo got %h want 3f", uo_out); else n_pass++;
    n_checks++; if (result_out !== 4'h0) $display("FAIL midclr_acc got %h want 0", result_out); else n_pass++;
    n_checks++; if (uio_out !== 8'h00) $display("FAIL midclr_uio got %h want 00", uio_out); else n_pass++;
    in_write_enable = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    cmd(2, 15, 0);
    n_checks++; if (result_out !== 4'h0) $display("FAIL midclr_ld got %h want 0", result_out); else n_pass++;
  endtask

  task automatic test_random();
    int op, addr, data, bc, want_bc;
    logic [DW-1:0] exp_acc;
    exp_q.delete();
    for (int n = 0; n < 40; n++) begin
      op = $urandom_range(0, 15);
      if (op == 12 && $urandom_range(0, 2) != 0) op = 1;
      addr = $urandom_range(0, DEP - 1);
      data = $urandom_range(0, MOD - 1);
      drive_cmd(op, addr, data, bc);
      model_cmd(op, addr, data);
      want_bc = (op == 12) ? DEP : 3;
      exp_acc = exp_q.pop_front();
      n_checks++; if (bc !== want_bc) $display("FAIL rnd_busy op=%0d got %0d want %0d", op, bc, want_bc); else n_pass++;
      n_checks++; if (result_out !== exp_acc) $display("FAIL rnd_acc op=%0d got %h want %h", op, result_out, exp_acc); else n_pass++;
      n_checks++;
      if (uio_out !== {4'b0, m_err[0], m_carry[0], m_zero[0], 1'b0})
        $display("FAIL rnd_flags op=%0d got %b want e%0d c%0d z%0d", op, uio_out, m_err, m_carry, m_zero);
      else n_pass++;
      n_checks++;
      if (uo_out[6:0] !== seg_tab[exp_acc[3:0]])
        $display("FAIL rnd_seg op=%0d got %h want %h", op, uo_out[6:0], seg_tab[exp_acc[3:0]]);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_xor();
    test_clear();
    test_busy_drop();
    test_ena_and_reserved();
    test_back_to_back();
    test_reset_mid_clear();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
